prio_arbiter: RTL

PRIO_ARBITER -- requirements
Module: prio_arbiter

---
 rtl/prio_pkg.sv | 17 +
 rtl/prio_arbiter_if.sv | 28 ++
 rtl/prio_enc_n.sv | 25 ++
 rtl/prio_arbiter.sv | 105 ++++++++++
 4 files changed

// File: rtl/prio_pkg.sv
// Shared definitions for the priority arbiter: mode encodings, FSM states and a width helper.
package prio_pkg;

    localparam int unsigned MODE_FIXED = 0;
    localparam int unsigned MODE_RR    = 1;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    // ceil(log2(v)), but never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/prio_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface prio_arbiter_if #(
    parameter int unsigned N = 8
) ();
    import prio_pkg::*;

    localparam int unsigned IW = clog2_min1(N);

    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid
    );

endinterface

// File: rtl/prio_enc_n.sv
// N-input combinational priority encoder; the highest set index wins.
module prio_enc_n
    import prio_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]                req_i,
    output logic [clog2_min1(N)-1:0]    idx_o,
    output logic                        found_o
);

    localparam int unsigned IW = clog2_min1(N);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i]) begin
                idx_o   = IW'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_arbiter.sv
// N-way arbiter with fixed-priority or round-robin selection and a bounded grant tenure.
module prio_arbiter
    import prio_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned MODE     = MODE_FIXED,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic           clk,
    input  logic           rst,
    prio_arbiter_if.slave  bus
);

    localparam int unsigned IW = clog2_min1(N);
    localparam int unsigned HW = clog2_min1(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_e        state_q;
    logic [N-1:0]  gnt_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] ptr_q;
    logic          valid_q;
    logic [HW-1:0] hold_q;

    logic [N-1:0]  enc_in;
    logic [IW-1:0] enc_idx;
    logic          enc_found;
    logic [IW-1:0] win_idx;
    logic          expired;
    logic          owner_keep;

    // Round-robin: search position j (starting at ptr+1) lands on encoder bit N-1-j, so the
    // first position searched is the one the highest-wins encoder prefers.
    always_comb begin
        enc_in = bus.req;
        if (MODE == MODE_RR) begin
            for (int j = 0; j < N; j++) begin
                int unsigned k;
                k = int'(ptr_q) + 1 + j;
                if (k >= N) begin
                    k = k - N;
                end
                enc_in[N-1-j] = bus.req[k];
            end
        end
    end

    prio_enc_n #(
        .N (N)
    ) u_enc (
        .req_i   (enc_in),
        .idx_o   (enc_idx),
        .found_o (enc_found)
    );

    always_comb begin
        int unsigned w;
        w       = 0;
        win_idx = enc_idx;
        if (MODE == MODE_RR) begin
            w = int'(ptr_q) + N - int'(enc_idx);
            if (w >= N) begin
                w = w - N;
            end
            win_idx = IW'(w);
        end
    end

    assign expired    = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
    assign owner_keep = (state_q == StGrant) && bus.req[idx_q] && !expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
            ptr_q   <= IW'(N - 1);
        end else if (owner_keep) begin
            // Saturate so an unlimited tenure never wraps the counter.
            if (hold_q != '1) begin
                hold_q <= hold_q + 1'b1;
            end
        end else if (enc_found) begin
            state_q <= StGrant;
            gnt_q   <= {{(N-1){1'b0}}, 1'b1} << win_idx;
            idx_q   <= win_idx;
            ptr_q   <= win_idx;
            valid_q <= 1'b1;
            hold_q  <= '0;
        end else begin
            state_q <= StIdle;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;

endmodule
